// File: rtl/fc_pkg.sv
// fc_pkg: shared state encoding and sizing helper
// for the fully-connected layer sequencer.
package fc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    BIAS,
    MAC,
    DRAIN,
    WRITE,
    DONE
  } state_t;

  // Never returns 0 so a width derived from it is always legal.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int k = 0; k < 31; k++) begin
      if ((1 << k) < v) r = k + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/fc_layer_seq_if.sv
// fc_layer_seq_if: BRAM read ports, MAC strobes and
// status of the fully-connected layer sequencer.
interface fc_layer_seq_if #(
  parameter int AW_B = 7,
  parameter int AW_W = 16,
  parameter int AW_F = 9,
  parameter int IW   = 7
);
  logic            bias_bram_ena;
  logic [AW_B-1:0] bias_bram_addra;
  logic            bias_bram_enb;
  logic [AW_B-1:0] bias_bram_addrb;
  logic            w_bram_ena;
  logic            w_bram_enb;
  logic [AW_W-1:0] w_bram_addra;
  logic [AW_W-1:0] w_bram_addrb;
  logic            fm_bram_ena;
  logic [AW_F-1:0] fm_bram_addra;
  logic            acc_ld;
  logic            acc_mac;
  logic            acc_b_vld;
  logic            out_wr;
  logic [IW-1:0]   out_idx;
  logic            busy;
  logic            fc_finish;

  modport master (
    output bias_bram_ena, bias_bram_addra,
    output bias_bram_enb, bias_bram_addrb,
    output w_bram_ena, w_bram_enb,
    output w_bram_addra, w_bram_addrb,
    output fm_bram_ena, fm_bram_addra,
    output acc_ld, acc_mac, acc_b_vld,
    output out_wr, out_idx, busy, fc_finish
  );

  modport slave (
    input bias_bram_ena, bias_bram_addra,
    input bias_bram_enb, bias_bram_addrb,
    input w_bram_ena, w_bram_enb,
    input w_bram_addra, w_bram_addrb,
    input fm_bram_ena, fm_bram_addra,
    input acc_ld, acc_mac, acc_b_vld,
    input out_wr, out_idx, busy, fc_finish
  );
endinterface

// File: rtl/fc_vld_pipe.sv
// fc_vld_pipe: delays the {ld, mac} issue strobes by the
// BRAM read latency so they line up with returning data.
module fc_vld_pipe #(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [1:0] din,
  output logic [1:0] dout
);
  logic [1:0] sr [DEPTH];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int k = 0; k < DEPTH; k++) sr[k] <= '0;
    end else begin
      sr[0] <= din;
      for (int k = 1; k < DEPTH; k++) sr[k] <= sr[k-1];
    end
  end

  assign dout = sr[DEPTH-1];
endmodule

// File: rtl/fc_layer_seq.sv
// fc_layer_seq: sequences one fully-connected layer two
// neurons at a time (lane A even, lane B odd).
module fc_layer_seq
  import fc_pkg::*;
#(
  parameter int N_IN      = 400,
  parameter int N_OUT     = 120,
  parameter int BIAS_BASE = 11,
  parameter int W_BASE    = 0,
  parameter int FM_BASE   = 0,
  parameter int BRAM_LAT  = 2,
  parameter int AW_B      = 7,
  parameter int AW_W      = 16,
  parameter int AW_F      = 9
) (
  input  logic clk,
  input  logic rst,
  input  logic fc_en,
  fc_layer_seq_if.master bus
);
  localparam int CI = clog2(N_IN);
  localparam int CO = clog2(N_OUT);
  localparam int CD = clog2(BRAM_LAT);

  state_t state, state_nx;
  logic fc_en_d, armed, abort;
  logic [CO-1:0] n, n_nx;
  logic [CI-1:0] i, i_nx;
  logic [CD-1:0] d, d_nx;
  logic [AW_W-1:0] wbase, wbase_nx;

  logic bea, bea_nx, beb, beb_nx;
  logic wea, wea_nx, web, web_nx;
  logic fe, fe_nx, bvld, bvld_nx;
  logic wr, wr_nx, busy, busy_nx;
  logic fin, fin_nx;
  logic [AW_B-1:0] ba, ba_nx, bb, bb_nx;
  logic [AW_W-1:0] wa, wa_nx, wb, wb_nx;
  logic [AW_F-1:0] fa, fa_nx;
  logic [CO-1:0] oidx, oidx_nx;
  logic [1:0] acc;

  assign abort = !fc_en && (state != IDLE);

  always_comb begin
    state_nx = state;
    n_nx     = n;
    i_nx     = i;
    d_nx     = d;
    wbase_nx = wbase;
    unique case (state)
      IDLE:
        if (fc_en && !fc_en_d && armed) state_nx = BIAS;
      BIAS: begin
        state_nx = MAC;
        i_nx     = '0;
      end
      MAC:
        if (i == CI'(N_IN - 1)) begin
          state_nx = DRAIN;
          d_nx     = '0;
        end else begin
          i_nx = i + CI'(1);
        end
      DRAIN:
        if (d == CD'(BRAM_LAT - 1)) state_nx = WRITE;
        else d_nx = d + CD'(1);
      WRITE:
        if (int'(n) + 2 >= N_OUT) begin
          state_nx = DONE;
        end else begin
          state_nx = BIAS;
          n_nx     = n + CO'(2);
          wbase_nx = wbase + AW_W'(2 * N_IN);
        end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (abort) state_nx = IDLE;
    if (state_nx == IDLE) begin
      n_nx     = '0;
      i_nx     = '0;
      d_nx     = '0;
      wbase_nx = AW_W'(W_BASE);
    end
  end

  // Outputs are registered against the next state so they
  // appear in the same cycle the state does.
  always_comb begin
    bea_nx  = 1'b0;
    beb_nx  = 1'b0;
    wea_nx  = 1'b0;
    web_nx  = 1'b0;
    fe_nx   = 1'b0;
    wr_nx   = 1'b0;
    fin_nx  = 1'b0;
    ba_nx   = ba;
    bb_nx   = bb;
    wa_nx   = wa;
    wb_nx   = wb;
    fa_nx   = fa;
    oidx_nx = oidx;
    bvld_nx = bvld;
    busy_nx = (state_nx != IDLE);
    unique case (state_nx)
      BIAS: begin
        bea_nx  = 1'b1;
        ba_nx   = AW_B'(BIAS_BASE) + AW_B'(n_nx);
        bb_nx   = ba_nx + AW_B'(1);
        bvld_nx = (int'(n_nx) + 1 != N_OUT);
        beb_nx  = bvld_nx;
      end
      MAC: begin
        fe_nx  = 1'b1;
        fa_nx  = AW_F'(FM_BASE) + AW_F'(i_nx);
        wea_nx = 1'b1;
        web_nx = bvld;
        wa_nx  = wbase_nx + AW_W'(i_nx);
        wb_nx  = wa_nx + AW_W'(N_IN);
      end
      WRITE: begin
        wr_nx   = 1'b1;
        oidx_nx = n_nx;
      end
      DONE: fin_nx = 1'b1;
      IDLE: bvld_nx = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      fc_en_d <= 1'b0;
      armed   <= !fc_en;
      n       <= '0;
      i       <= '0;
      d       <= '0;
      wbase   <= AW_W'(W_BASE);
      bea     <= 1'b0;
      beb     <= 1'b0;
      wea     <= 1'b0;
      web     <= 1'b0;
      fe      <= 1'b0;
      wr      <= 1'b0;
      fin     <= 1'b0;
      busy    <= 1'b0;
      bvld    <= 1'b0;
      ba      <= '0;
      bb      <= '0;
      wa      <= '0;
      wb      <= '0;
      fa      <= '0;
      oidx    <= '0;
    end else begin
      state   <= state_nx;
      fc_en_d <= fc_en;
      armed   <= armed || !fc_en;
      n       <= n_nx;
      i       <= i_nx;
      d       <= d_nx;
      wbase   <= wbase_nx;
      bea     <= bea_nx;
      beb     <= beb_nx;
      wea     <= wea_nx;
      web     <= web_nx;
      fe      <= fe_nx;
      wr      <= wr_nx;
      fin     <= fin_nx;
      busy    <= busy_nx;
      bvld    <= bvld_nx;
      ba      <= ba_nx;
      bb      <= bb_nx;
      wa      <= wa_nx;
      wb      <= wb_nx;
      fa      <= fa_nx;
      oidx    <= oidx_nx;
    end
  end

  fc_vld_pipe #(.DEPTH(BRAM_LAT)) u_pipe (
    .clk  (clk),
    .clr  (rst || abort),
    .din  ({bea, fe}),
    .dout (acc)
  );

  assign bus.bias_bram_ena   = bea;
  assign bus.bias_bram_addra = ba;
  assign bus.bias_bram_enb   = beb;
  assign bus.bias_bram_addrb = bb;
  assign bus.w_bram_ena      = wea;
  assign bus.w_bram_enb      = web;
  assign bus.w_bram_addra    = wa;
  assign bus.w_bram_addrb    = wb;
  assign bus.fm_bram_ena     = fe;
  assign bus.fm_bram_addra   = fa;
  assign bus.acc_ld          = acc[1];
  assign bus.acc_mac         = acc[0];
  assign bus.acc_b_vld       = bvld;
  assign bus.out_wr          = wr;
  assign bus.out_idx         = oidx;
  assign bus.busy            = busy;
  assign bus.fc_finish       = fin;
endmodule

// File: tb/tb_fc_layer_seq.sv
// tb_fc_layer_seq: drives N_OUT=4 and N_OUT=5 instances with
// directed and random layers against a trace model.
module tb_fc_layer_seq;
  import fc_pkg::*;

  localparam int NI  = 4;
  localparam int LAT = 2;
  localparam int BB  = 11;

  typedef struct packed {
    logic bea, beb;
    logic [6:0] ba, bb;
    logic wea, web;
    logic [15:0] wa, wb;
    logic fe;
    logic [8:0] fa;
    logic ld, mac, bv, wr;
    logic [7:0] idx;
    logic busy, fin;
  } obs_t;

  typedef struct {
    bit odd;
    int cyc;
    int fld;
    int val;
  } vec_t;

  localparam int F_BA = 0, F_BB = 1, F_BENB = 2, F_WA = 3;
  localparam int F_WB = 4, F_WENB = 5, F_WR = 6, F_IDX = 7;
  localparam int F_FIN = 8, F_BUSY = 9, F_MAC = 10;
  localparam int F_LD = 11, F_BV = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en4 = 1'b0;
  logic en5 = 1'b0;
  int n_cmp = 0;
  int n_err = 0;
  obs_t exp_q[$];
  obs_t log4 [32];
  obs_t log5 [32];
  vec_t vt[$];

  always #5 clk = ~clk;

  fc_layer_seq_if #(.AW_B(7), .AW_W(16), .AW_F(9), .IW(2)) bus4 ();
  fc_layer_seq_if #(.AW_B(7), .AW_W(16), .AW_F(9), .IW(3)) bus5 ();

  fc_layer_seq #(.N_IN(NI), .N_OUT(4), .BRAM_LAT(LAT)) dut4 (
    .clk(clk), .rst(rst), .fc_en(en4), .bus(bus4)
  );
  fc_layer_seq #(.N_IN(NI), .N_OUT(5), .BRAM_LAT(LAT)) dut5 (
    .clk(clk), .rst(rst), .fc_en(en5), .bus(bus5)
  );

  function automatic obs_t sample(input bit odd);
    obs_t o;
    if (odd) begin
      o = '{bus5.bias_bram_ena, bus5.bias_bram_enb,
            bus5.bias_bram_addra, bus5.bias_bram_addrb,
            bus5.w_bram_ena, bus5.w_bram_enb,
            bus5.w_bram_addra, bus5.w_bram_addrb,
            bus5.fm_bram_ena, bus5.fm_bram_addra,
            bus5.acc_ld, bus5.acc_mac, bus5.acc_b_vld,
            bus5.out_wr, 8'(bus5.out_idx),
            bus5.busy, bus5.fc_finish};
    end else begin
      o = '{bus4.bias_bram_ena, bus4.bias_bram_enb,
            bus4.bias_bram_addra, bus4.bias_bram_addrb,
            bus4.w_bram_ena, bus4.w_bram_enb,
            bus4.w_bram_addra, bus4.w_bram_addrb,
            bus4.fm_bram_ena, bus4.fm_bram_addra,
            bus4.acc_ld, bus4.acc_mac, bus4.acc_b_vld,
            bus4.out_wr, 8'(bus4.out_idx),
            bus4.busy, bus4.fc_finish};
    end
    return o;
  endfunction

  // Addresses only matter while their enable is up.
  function automatic bit match(input obs_t a, input obs_t e);
    bit ok;
    ok = {a.bea, a.beb, a.wea, a.web, a.fe, a.ld, a.mac,
          a.bv, a.wr, a.busy, a.fin} ===
         {e.bea, e.beb, e.wea, e.web, e.fe, e.ld, e.mac,
          e.bv, e.wr, e.busy, e.fin};
    if (e.bea) ok = ok && a.ba === e.ba && a.bb === e.bb;
    if (e.wea) ok = ok && a.wa === e.wa && a.wb === e.wb;
    if (e.fe) ok = ok && a.fa === e.fa;
    if (e.wr) ok = ok && a.idx === e.idx;
    return ok;
  endfunction

  function automatic int fld(input obs_t o, input int f);
    case (f)
      F_BA:    return int'(o.ba);
      F_BB:    return int'(o.bb);
      F_BENB:  return int'(o.beb);
      F_WA:    return int'(o.wa);
      F_WB:    return int'(o.wb);
      F_WENB:  return int'(o.web);
      F_WR:    return int'(o.wr);
      F_IDX:   return int'(o.idx);
      F_FIN:   return int'(o.fin);
      F_BUSY:  return int'(o.busy);
      F_MAC:   return int'(o.mac);
      F_LD:    return int'(o.ld);
      default: return int'(o.bv);
    endcase
  endfunction

  task automatic check(input obs_t a, input obs_t e,
                       input string nm, input int k);
    n_cmp++;
    if (!match(a, e)) begin
      n_err++;
      $display("FAIL %s k=%0d got=%h want=%h", nm, k, a, e);
    end
  endtask

  task automatic cmp_int(input string nm, input int got,
                         input int want);
    n_cmp++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask

  // Per-cycle trace of one layer straight from the pair rules.
  task automatic build(input int nout);
    obs_t c;
    c = '0;
    exp_q.delete();
    for (int p = 0; 2 * p < nout; p++) begin
      c.bea = 1'b1;
      c.ba = 7'(BB + 2 * p);
      c.bb = 7'(BB + 2 * p + 1);
      c.bv = (2 * p + 1 < nout);
      c.beb = c.bv;
      c.busy = 1'b1;
      exp_q.push_back(c);
      c.bea = 1'b0;
      c.beb = 1'b0;
      for (int i = 0; i < NI; i++) begin
        c.fe = 1'b1;
        c.fa = 9'(i);
        c.wea = 1'b1;
        c.web = c.bv;
        c.wa = 16'(2 * p * NI + i);
        c.wb = 16'((2 * p + 1) * NI + i);
        exp_q.push_back(c);
      end
      c.fe = 1'b0;
      c.wea = 1'b0;
      c.web = 1'b0;
      repeat (LAT) exp_q.push_back(c);
      c.wr = 1'b1;
      c.idx = 8'(2 * p);
      exp_q.push_back(c);
      c.wr = 1'b0;
    end
    c.fin = 1'b1;
    exp_q.push_back(c);
    c.fin = 1'b0;
    c.busy = 1'b0;
    c.bv = 1'b0;
    exp_q.push_back(c);
    for (int t = LAT; t < exp_q.size(); t++) begin
      c = exp_q[t];
      c.ld = exp_q[t-LAT].bea;
      c.mac = exp_q[t-LAT].fe;
      exp_q[t] = c;
    end
  endtask

  task automatic set_en(input bit odd, input logic v);
    if (odd) en5 = v;
    else en4 = v;
  endtask

  task automatic put_log(input bit odd, input int k, input obs_t o);
    if (odd) log5[k] = o;
    else log4[k] = o;
  endtask

  // mode 0 clean, 1 abort before trace index k, 2 glitch in cycle k.
  task automatic run_layer(input bit odd, input int mode,
                           input int k_ev, input bit logit);
    obs_t o;
    int len;
    bit bad;
    build(odd ? 5 : 4);
    len = exp_q.size();
    @(posedge clk);
    #1;
    set_en(odd, 1'b1);
    if (logit) put_log(odd, 0, sample(odd));
    for (int k = 0; k < len; k++) begin
      if (mode == 1 && k == k_ev) set_en(odd, 1'b0);
      if (mode == 2 && k == k_ev) begin
        #2 set_en(odd, 1'b0);
        #2 set_en(odd, 1'b1);
      end
      @(posedge clk);
      #1;
      o = sample(odd);
      if (logit) put_log(odd, k + 1, o);
      if (mode == 1 && k == k_ev) begin
        check(o, '0, "abort_idle", k);
        break;
      end
      check(o, exp_q[k], "trace", k);
    end
    set_en(odd, 1'b0);
    bad = 1'b0;
    repeat (24) begin
      @(posedge clk);
      #1;
      o = sample(odd);
      if (o.fin || o.busy) bad = 1'b1;
    end
    cmp_int("quiet_after_layer", int'(bad), 0);
  endtask

  task automatic add(input bit odd, input int cyc,
                     input int f, input int v);
    vec_t r;
    r = '{odd, cyc, f, v};
    vt.push_back(r);
  endtask

  task automatic reset_mid_layer();
    obs_t o;
    bit restarted;
    @(posedge clk);
    #1;
    en4 = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    o = sample(1'b0);
    n_cmp++;
    if (o !== '0) begin
      n_err++;
      $display("FAIL rst_mid_zero got=%h want=0", o);
    end
    rst = 1'b0;
    restarted = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (bus4.busy || bus4.bias_bram_ena) restarted = 1'b1;
    end
    cmp_int("no_restart_after_rst", int'(restarted), 0);
    en4 = 1'b0;
    run_layer(1'b0, 0, 0, 1'b0);
  endtask

  initial begin
    obs_t o;
    int len, k, md;
    bit odd;

    // Cycle numbers count the cycle fc_en rises in as cycle 1.
    add(0, 1, F_BUSY, 0);
    add(0, 2, F_BA, 11);
    add(0, 2, F_BB, 12);
    add(0, 2, F_BUSY, 1);
    add(0, 3, F_WA, 0);
    add(0, 3, F_WB, 4);
    add(0, 4, F_BA, 11);
    add(0, 9, F_WR, 1);
    add(0, 9, F_IDX, 0);
    add(0, 10, F_BA, 13);
    add(0, 10, F_BB, 14);
    add(0, 11, F_WA, 8);
    add(0, 11, F_WB, 12);
    add(0, 14, F_WA, 11);
    add(0, 14, F_WB, 15);
    add(0, 12, F_LD, 1);
    add(0, 12, F_MAC, 0);
    add(0, 13, F_MAC, 1);
    add(0, 16, F_MAC, 1);
    add(0, 17, F_MAC, 0);
    add(0, 17, F_WR, 1);
    add(0, 17, F_IDX, 2);
    add(0, 17, F_FIN, 0);
    add(0, 18, F_FIN, 1);
    add(0, 18, F_BUSY, 1);
    add(0, 19, F_FIN, 0);
    add(0, 19, F_BUSY, 0);
    add(1, 2, F_BENB, 1);
    add(1, 2, F_BV, 1);
    add(1, 18, F_BA, 15);
    add(1, 18, F_BENB, 0);
    add(1, 18, F_BV, 0);
    add(1, 19, F_WENB, 0);
    add(1, 19, F_WA, 16);
    add(1, 19, F_WB, 20);
    add(1, 25, F_WR, 1);
    add(1, 25, F_IDX, 4);
    add(1, 26, F_FIN, 1);

    repeat (3) @(posedge clk);
    #1;
    o = sample(1'b0);
    n_cmp++;
    if (o !== '0) begin
      n_err++;
      $display("FAIL reset4 got=%h want=0", o);
    end
    o = sample(1'b1);
    n_cmp++;
    if (o !== '0) begin
      n_err++;
      $display("FAIL reset5 got=%h want=0", o);
    end
    rst = 1'b0;

    run_layer(1'b0, 0, 0, 1'b1);
    run_layer(1'b1, 0, 0, 1'b1);
    foreach (vt[j]) begin
      o = vt[j].odd ? log5[vt[j].cyc-1] : log4[vt[j].cyc-1];
      n_cmp++;
      if (fld(o, vt[j].fld) != vt[j].val) begin
        n_err++;
        $display("FAIL vec%0d odd=%0d cyc=%0d fld=%0d got=%0d want=%0d",
                 j, vt[j].odd, vt[j].cyc, vt[j].fld,
                 fld(o, vt[j].fld), vt[j].val);
      end
    end

    run_layer(1'b0, 1, 3, 1'b0);
    run_layer(1'b0, 0, 0, 1'b0);
    run_layer(1'b0, 2, 5, 1'b0);
    reset_mid_layer();

    for (int it = 0; it < 16; it++) begin
      odd = 1'($urandom_range(0, 1));
      md = $urandom_range(0, 2);
      len = odd ? 26 : 18;
      k = $urandom_range(1, len - 2);
      run_layer(odd, md, k, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule
